// File: rtl/imem_fetch_unit.sv
// Byte-serial instruction fetch: four byte reads per instruction, little-endian assembly, valid/ready to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (unaligned redirects become a misaligned-instruction token).
module imem_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [7:0]            imem_data_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  instr_misaligned_o
`endif
);

  // S_IDLE is only reachable after a misaligned token has been consumed.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LAST  = 2'd1,
    S_VALID = 2'd2,
    S_IDLE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           buf_q, buf_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;
  logic                  mis_q, mis_d;
  logic                  redirect_misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign instr_misaligned_o  = mis_q;
`else
  assign redirect_misaligned = 1'b0;
`endif

  assign imem_addr_o   = (state_q == S_FETCH) ? (pc_q + ADDR_WIDTH'(idx_q)) : pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      idx_q      <= 2'd0;
      buf_q      <= 24'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
    end
  end

  // Redirect wins over everything; idx=0 after it means the stale returning byte is never captured.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    mis_d      = mis_q;

    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i;
      idx_d   = 2'd0;
      valid_d = 1'b0;
      mis_d   = 1'b0;
      state_d = S_FETCH;
      if (redirect_misaligned) begin
        state_d    = S_VALID;
        valid_d    = 1'b1;
        instr_d    = 32'd0;
        instr_pc_d = redirect_pc_i;
        mis_d      = 1'b1;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          case (idx_q)
            2'd1:    buf_d[7:0]   = imem_data_i;
            2'd2:    buf_d[15:8]  = imem_data_i;
            2'd3:    buf_d[23:16] = imem_data_i;
            default: buf_d        = buf_q;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_LAST;
          end
        end
        S_LAST: begin
          instr_d    = {imem_data_i, buf_q};
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_VALID;
        end
        S_VALID: begin
          if (instr_ready_i) begin
            valid_d = 1'b0;
            if (mis_q) begin
              state_d = S_IDLE;
            end else begin
              pc_d    = pc_q + ADDR_WIDTH'(4);
              idx_d   = 2'd0;
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed test-plan sequences then random traffic against a cycle-count reference model.
module tb_imem_fetch_unit;

  logic        clk;
  logic        rstN;
  logic [31:0] imemAddr;
  logic [7:0]  imemData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        instrMisaligned;
`endif

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0] memArr [0:255];

  // Reference model: fetch start PC plus edges elapsed since that fetch began.
  logic [31:0] mPc;
  int          mCnt;
  bit          mMis;
  bit          mIdle;

  imem_fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rstN),
    .imem_addr_o     (imemAddr),
    .imem_data_i     (imemData),
    .redirect_valid_i(redirectValid),
    .redirect_pc_i   (redirectPc),
    .instr_valid_o   (instrValid),
    .instr_ready_i   (instrReady),
    .instr_o         (instr),
    .instr_pc_o      (instrPc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .instr_misaligned_o(instrMisaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imemData <= memArr[imemAddr[7:0]];

  function automatic logic [7:0] memByte(input logic [31:0] a);
    return memArr[a[7:0]];
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc   = 32'h0;
    mCnt  = 0;
    mMis  = 1'b0;
    mIdle = 1'b0;
  endtask

  function automatic bit modelValid();
    return (mCnt >= 5) && !mIdle;
  endfunction

  task automatic modelStep(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit v;
    v = modelValid();
    if (rv) begin
      mPc   = rpc;
      mIdle = 1'b0;
      mMis  = 1'b0;
      mCnt  = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin
        mMis = 1'b1;
        mCnt = 5;
      end
`endif
    end else if (v && rdy) begin
      if (mMis) begin
        mIdle = 1'b1;
      end else begin
        mPc  = mPc + 32'd4;
        mCnt = 0;
      end
    end else if (mCnt < 5) begin
      mCnt++;
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model across the posedge.
  task automatic applyStimulus(input bit rstIn, input bit rv, input logic [31:0] rpc, input bit rdy);
    logic [31:0] expAddr;
    @(negedge clk);
    rstN          = rstIn;
    redirectValid = rv;
    redirectPc    = rpc;
    instrReady    = rdy;
    if (!rstIn) modelReset();
    #1;
    expAddr = (!mIdle && mCnt < 4) ? (mPc + 32'(mCnt)) : mPc;
    checkOutput("imem_addr", imemAddr, expAddr);
    checkOutput("instr_valid", {31'd0, instrValid}, {31'd0, modelValid()});
    if (modelValid()) begin
      checkOutput("instr", instr, mMis ? 32'd0 : memWord(mPc));
      checkOutput("instr_pc", instrPc, mPc);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    checkOutput("instr_misaligned", {31'd0, instrMisaligned}, {31'd0, mMis});
`endif
    if (!rstIn) begin
      checkOutput("reset instr", instr, 32'd0);
      checkOutput("reset instr_pc", instrPc, 32'd0);
    end
    @(posedge clk);
    if (rstIn) modelStep(rv, rpc, rdy);
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, rdy);
  endtask

  initial begin
    rstN          = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'd0;
    instrReady    = 1'b0;
    modelReset();
    for (int i = 0; i < 256; i++) memArr[i] = 8'($urandom);
    {memArr[3], memArr[2], memArr[1], memArr[0]} = 32'h00A00513;
    {memArr[7], memArr[6], memArr[5], memArr[4]} = 32'h00B505B3;

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    // First instruction out of reset: valid after the 5th edge.
    idleCycles(5, 1'b1);
    #2;
    checkOutput("first valid", {31'd0, instrValid}, 32'd1);
    checkOutput("first instr", instr, 32'h00A00513);
    checkOutput("first pc", instrPc, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    #2;
    checkOutput("next fetch addr", imemAddr, 32'h4);

    // Backpressure holds the instruction and address stable.
    idleCycles(15, 1'b0);
    #2;
    checkOutput("bp instr", instr, 32'h00B505B3);
    checkOutput("bp pc", instrPc, 32'h4);
    checkOutput("bp addr", imemAddr, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    #2;
    checkOutput("bp pc advance", imemAddr, 32'h8);

    // Redirect while idx=2.
    idleCycles(2, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b0);
    #2;
    checkOutput("redir addr", imemAddr, 32'h10);
    idleCycles(5, 1'b0);
    #2;
    checkOutput("redir pc", instrPc, 32'h10);
    checkOutput("redir instr", instr, memWord(32'h10));

    // Redirect coincident with handshake.
    applyStimulus(1'b1, 1'b1, 32'h8, 1'b1);
    #2;
    checkOutput("redir+hs valid", {31'd0, instrValid}, 32'd0);
    checkOutput("redir+hs addr", imemAddr, 32'h8);
    idleCycles(5, 1'b0);
    #2;
    checkOutput("redir+hs pc", instrPc, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Held redirect never produces an instruction.
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h48, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h20, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h24, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h28, 1'b1);

    // Address wrap, then reset in the middle of that fetch.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    #2;
    checkOutput("wrap a0", imemAddr, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("wrap a1", imemAddr, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("wrap a2", imemAddr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    #2;
    checkOutput("wrap a3", imemAddr, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    idleCycles(5, 1'b0);
    #2;
    checkOutput("post-reset instr", instr, 32'h00A00513);
    checkOutput("post-reset pc", instrPc, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Unaligned redirect.
    applyStimulus(1'b1, 1'b1, 32'h6, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    #2;
    checkOutput("trap valid", {31'd0, instrValid}, 32'd1);
    checkOutput("trap flag", {31'd0, instrMisaligned}, 32'd1);
    checkOutput("trap instr", instr, 32'd0);
    checkOutput("trap pc", instrPc, 32'h6);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    idleCycles(3, 1'b1);
    #2;
    checkOutput("trap idle addr", imemAddr, 32'h6);
    applyStimulus(1'b1, 1'b1, 32'h8, 1'b0);
    idleCycles(5, 1'b0);
    #2;
    checkOutput("resume flag", {31'd0, instrMisaligned}, 32'd0);
    checkOutput("resume pc", instrPc, 32'h8);
`else
    idleCycles(5, 1'b0);
    #2;
    checkOutput("unaligned pc", instrPc, 32'h6);
    checkOutput("unaligned instr", instr, {memArr[9], memArr[8], memArr[7], memArr[6]});
`endif
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit          rstIn;
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      rstIn = ($urandom_range(0, 99) != 0);
      rv    = ($urandom_range(0, 11) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      rpc   = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 63));
      applyStimulus(rstIn, rv, rpc, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
